alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, clocked successor to the project's 16-bit combinational ALU. It supports any even operand width and registers its result and flags. It adds a carry-out flag and a multi-cycle shift-add multiply, and uses a start/busy/done handshake. It sits between the register file and the writeback path of the datapath controller, which issues one operation at a time.

## Interface
- WIDTH, 16, operand and result width in bits; must be even and at least 4.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- start  input  1  operation request; sampled only when busy=0.
- inA  input  WIDTH  operand A, signed.
- inB  input  WIDTH  operand B, signed.
- opc  input  3  operation select.
- inc  input  1  carry-in; used by opc 010 only.
- busy  output  1  high while a multiply is iterating.
- done  output  1  one-cycle pulse when w and the flags take a new result.
- w  output  WIDTH  registered result; holds its value between operations.
- zer  output  1  registered; high when w == 0.
- neg  output  1  registered; equals w[WIDTH-1].
- cout  output  1  registered carry out of bit WIDTH-1.

## Operation
- 000: w = ~inA + 1. cout = 1 only when inA == 0.
- 001: w = inA + 1. cout = carry out of the unsigned sum.
- 010: w = inA + inB + inc. cout = carry out of the unsigned sum.
- 011: w = inA + (inB >>> 1), arithmetic shift with sign fill. cout = carry out of the unsigned sum.
- 100: w = inA & inB. cout = 0.
- 101: w = inA | inB. cout = 0.
- 110: w = {inA[WIDTH/2-1:0], inB[WIDTH/2-1:0]}. cout = 0.
- 111: w = low WIDTH bits of inA*inB. These bits are identical for signed and unsigned operands. cout = 0.
- All sums are WIDTH+1 bits wide internally. w takes the low WIDTH bits; bit WIDTH drives cout.
- zer and neg are computed from the new w value and load on the same edge as w.
- State machine:
  - IDLE: start=1 with opc != 111 computes the result and loads w and the flags; stay in IDLE. start=1 with opc == 111 captures inA, inB and clears the accumulator; go to MUL with counter = 0.
  - MUL: each cycle, if multiplier bit 0 = 1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++. After WIDTH iterations, load w and flags from acc, pulse done, and return to IDLE.
- Operands, opc and inc are captured at start. Later changes to them do not affect an operation in flight.
- A start while busy=1 is ignored; it is not queued.
- start may be high on the cycle done is high (back-to-back). It is accepted whenever busy=0.

## Timing
- Reset (rstn low at an edge): w=0, zer=0, neg=0, cout=0, done=0, busy=0, state IDLE, counter and accumulator cleared.
- Single-cycle ops: start is sampled at edge k. After edge k, w, the flags and done=1 are valid. done drops after edge k+1 unless a new op is accepted.
- Multiply: start is sampled at edge k.
  - busy=1 after edge k, through edge k+WIDTH-1.
  - Iterations occur on edges k+1 through k+WIDTH.
  - w, the flags and done=1 are valid after edge k+WIDTH, with busy=0.
  - Latency is WIDTH cycles.
- Reset mid-multiply aborts the operation: no done pulse, and all outputs take their reset values on that edge.
- The first start after reset deassertion is accepted normally.
- w and the flags change only on a done edge or on reset.

## Test plan
- WIDTH=16, opc 010, inA=0x7FFF, inB=0x0001, inc=1 -> one cycle later w=0x8001, neg=1, zer=0, cout=0, and done high for exactly one cycle.
- opc 000, inA=0x0000 -> w=0x0000, zer=1, cout=1. Then opc 011, inA=0x0010, inB=0xFFF0 -> w=0x0008, cout=1, neg=0.
- opc 111, inA=0xFFFD (-3), inB=0x0007 -> busy high for 16 cycles, then w=0xFFEB (-21), neg=1, cout=0, done 16 cycles after start. Extra stimulus: a start with opc 100, plus changes to inA, pulsed 5 cycles in -> ignored, and the result is unchanged.
- opc 110, inA=0x12AB, inB=0x34CD -> w=0xABCD, neg=1. Also at WIDTH=8, opc 110, inA=0x1A, inB=0x2B -> w=0xAB.
- Back-to-back: opc 101, inA=0x00F0, inB=0x0F00, issued on the done cycle of a multiply -> w=0x0FF0 one cycle after that done, with no lost or duplicated done pulse.
- rstn low for one edge at cycle 8 of a multiply -> all outputs 0 and no done pulse. Next start with opc 001, inA=0xFFFF -> w=0x0000, zer=1, cout=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the datapath controller and alu_seq.
// The controller side drives the request; the ALU side returns the registered result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [2:0]       opc;
  logic             inc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] w;
  logic             zer;
  logic             neg;
  logic             cout;

  modport master (
    output start, inA, inB, opc, inc,
    input  busy, done, w, zer, neg, cout
  );

  modport slave (
    input  start, inA, inB, opc, inc,
    output busy, done, w, zer, neg, cout
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked ALU with registered result/flags, carry out, and a WIDTH-cycle shift-add multiply.
//   state  | meaning
//   S_IDLE | accepts start; single-cycle ops complete here, opc 111 launches a multiply
//   S_MUL  | one shift-add iteration per cycle; last iteration loads w and pulses done
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rstn,
  alu_seq_if.slave bus
);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("alu_seq: WIDTH must be even and at least 4");
  end

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] w_q;
  logic             zer_q;
  logic             neg_q;
  logic             cout_q;
  logic             done_q;

  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] b_sra;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_cout;
  logic             load;
  logic             cap;
  logic             iter;
  logic             last;

  assign b_sra   = $signed(bus.inB) >>> 1;
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cap       = 1'b0;
    iter      = 1'b0;
    sum       = '0;
    res       = '0;
    res_cout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.opc == 3'b111) begin
            cap       = 1'b1;
            state_nxt = S_MUL;
          end else begin
            load = 1'b1;
            case (bus.opc)
              3'b000: sum = {1'b0, ~bus.inA} + (WIDTH+1)'(1);
              3'b001: sum = {1'b0, bus.inA} + (WIDTH+1)'(1);
              3'b010: sum = {1'b0, bus.inA} + {1'b0, bus.inB} + (WIDTH+1)'(bus.inc);
              3'b011: sum = {1'b0, bus.inA} + {1'b0, b_sra};
              3'b100: sum = {1'b0, bus.inA & bus.inB};
              3'b101: sum = {1'b0, bus.inA | bus.inB};
              3'b110: sum = {1'b0, bus.inA[WIDTH/2-1:0], bus.inB[WIDTH/2-1:0]};
              default: sum = '0;
            endcase
            res = sum[WIDTH-1:0];
            // Logic ops and the concat never set bit WIDTH, so cout comes out 0 for them.
            res_cout = sum[WIDTH];
          end
        end
      end
      S_MUL: begin
        iter = 1'b1;
        if (last) begin
          load      = 1'b1;
          res       = acc_sum;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      w_q    <= '0;
      zer_q  <= 1'b0;
      neg_q  <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= load;
      if (cap) begin
        mcand  <= bus.inA;
        mplier <= bus.inB;
        acc    <= '0;
        cnt    <= '0;
      end else if (iter) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (load) begin
        w_q    <= res;
        zer_q  <= (res == '0);
        neg_q  <= res[WIDTH-1];
        cout_q <= res_cout;
      end
    end
  end

  assign bus.busy = (state == S_MUL);
  assign bus.done = done_q;
  assign bus.w    = w_q;
  assign bus.zer  = zer_q;
  assign bus.neg  = neg_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 and WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_pass;
  int   n_done;

  alu_seq_if #(.WIDTH(16)) a16 ();
  alu_seq_if #(.WIDTH(8))  a8 ();

  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rstn(rstn), .bus(a16));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rstn(rstn), .bus(a8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ci);
    a16.opc   = op;
    a16.inA   = a;
    a16.inB   = b;
    a16.inc   = ci;
    a16.start = 1'b1;
    tick();
    a16.start = 1'b0;
  endtask

  task automatic go8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic ci);
    a8.opc   = op;
    a8.inA   = a;
    a8.inB   = b;
    a8.inc   = ci;
    a8.start = 1'b1;
    tick();
    a8.start = 1'b0;
  endtask

  task automatic flags16(input string tag, input logic [15:0] ew, input logic ez,
                         input logic en, input logic ec);
    chk({tag, ".w"},    32'(a16.w),    32'(ew));
    chk({tag, ".zer"},  32'(a16.zer),  32'(ez));
    chk({tag, ".neg"},  32'(a16.neg),  32'(en));
    chk({tag, ".cout"}, 32'(a16.cout), 32'(ec));
    chk({tag, ".done"}, 32'(a16.done), 32'd1);
    chk({tag, ".busy"}, 32'(a16.busy), 32'd0);
  endtask

  task automatic all_zero16(input string tag);
    chk({tag, ".w"},    32'(a16.w),    32'd0);
    chk({tag, ".zer"},  32'(a16.zer),  32'd0);
    chk({tag, ".neg"},  32'(a16.neg),  32'd0);
    chk({tag, ".cout"}, 32'(a16.cout), 32'd0);
    chk({tag, ".done"}, 32'(a16.done), 32'd0);
    chk({tag, ".busy"}, 32'(a16.busy), 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rstn   = 1'b0;
    a16.start = 1'b0; a16.inA = '0; a16.inB = '0; a16.opc = '0; a16.inc = 1'b0;
    a8.start  = 1'b0; a8.inA  = '0; a8.inB  = '0; a8.opc  = '0; a8.inc  = 1'b0;
    tick();
    tick();
    all_zero16("rst16");
    chk("rst8.w",    32'(a8.w),    32'd0);
    chk("rst8.done", 32'(a8.done), 32'd0);
    chk("rst8.busy", 32'(a8.busy), 32'd0);
    rstn = 1'b1;
    tick();

    // add with carry-in: 0x7FFF + 1 + 1
    go16(3'b010, 16'h7FFF, 16'h0001, 1'b1);
    flags16("add", 16'h8001, 1'b0, 1'b1, 1'b0);
    tick();
    chk("add.done_drop", 32'(a16.done), 32'd0);
    chk("add.w_hold",    32'(a16.w),    32'h8001);

    go16(3'b000, 16'h0000, 16'h1234, 1'b0);
    flags16("neg0", 16'h0000, 1'b1, 1'b0, 1'b1);
    go16(3'b000, 16'h0005, 16'h0000, 1'b0);
    flags16("neg5", 16'hFFFB, 1'b0, 1'b1, 1'b0);
    go16(3'b011, 16'h0010, 16'hFFF0, 1'b0);
    flags16("sra", 16'h0008, 1'b0, 1'b0, 1'b1);
    go16(3'b001, 16'h7FFF, 16'h0000, 1'b0);
    flags16("inc", 16'h8000, 1'b0, 1'b1, 1'b0);
    go16(3'b100, 16'hF0F0, 16'h3C3C, 1'b0);
    flags16("and", 16'h3030, 1'b0, 1'b0, 1'b0);
    go16(3'b110, 16'h12AB, 16'h34CD, 1'b0);
    flags16("cat", 16'hABCD, 1'b0, 1'b1, 1'b0);
    tick();

    // -3 * 7 with an ignored start injected mid-flight
    go16(3'b111, 16'hFFFD, 16'h0007, 1'b0);
    chk("mul.busy0", 32'(a16.busy), 32'd1);
    chk("mul.done0", 32'(a16.done), 32'd0);
    a16.inA = 16'h1111;
    for (int i = 1; i < 16; i++) begin
      if (i == 5) begin
        a16.opc   = 3'b100;
        a16.inA   = 16'h5A5A;
        a16.inB   = 16'h0F0F;
        a16.start = 1'b1;
      end
      tick();
      a16.start = 1'b0;
      chk($sformatf("mul.busy%0d", i), 32'(a16.busy), 32'd1);
      chk($sformatf("mul.done%0d", i), 32'(a16.done), 32'd0);
      if (i == 10) chk("mul.w_hold", 32'(a16.w), 32'hABCD);
    end
    tick();
    flags16("mul", 16'hFFEB, 1'b0, 1'b1, 1'b0);
    tick();
    chk("mul.done_drop", 32'(a16.done), 32'd0);
    chk("mul.ign_w",     32'(a16.w),    32'hFFEB);
    chk("mul.ign_busy",  32'(a16.busy), 32'd0);

    // 3 * 5, then an OR issued on the done cycle
    go16(3'b111, 16'h0003, 16'h0005, 1'b0);
    n_done = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (a16.done) n_done++;
    end
    tick();
    chk("b2b.early_done", 32'(n_done), 32'd0);
    flags16("b2b.mul", 16'h000F, 1'b0, 1'b0, 1'b0);
    go16(3'b101, 16'h00F0, 16'h0F00, 1'b0);
    flags16("b2b.or", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b.done_drop", 32'(a16.done), 32'd0);
    chk("b2b.busy",      32'(a16.busy), 32'd0);

    go8(3'b110, 8'h1A, 8'h2B, 1'b0);
    chk("w8cat.w",    32'(a8.w),    32'hAB);
    chk("w8cat.neg",  32'(a8.neg),  32'd1);
    chk("w8cat.done", 32'(a8.done), 32'd1);
    go8(3'b010, 8'hFF, 8'h01, 1'b0);
    chk("w8add.w",    32'(a8.w),    32'h00);
    chk("w8add.zer",  32'(a8.zer),  32'd1);
    chk("w8add.cout", 32'(a8.cout), 32'd1);
    go8(3'b111, 8'hFE, 8'h05, 1'b0);
    for (int i = 1; i < 8; i++) tick();
    chk("w8mul.busy", 32'(a8.busy), 32'd1);
    tick();
    chk("w8mul.w",    32'(a8.w),    32'hF6);
    chk("w8mul.done", 32'(a8.done), 32'd1);
    chk("w8mul.busy_end", 32'(a8.busy), 32'd0);
    tick();

    // reset on the 8th cycle of a multiply
    go16(3'b111, 16'hFFFD, 16'h0007, 1'b0);
    for (int i = 1; i < 8; i++) tick();
    chk("abort.busy_pre", 32'(a16.busy), 32'd1);
    rstn = 1'b0;
    tick();
    all_zero16("abort");
    rstn = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a16.done || a16.busy) n_done++;
    end
    chk("abort.no_done", 32'(n_done), 32'd0);
    go16(3'b001, 16'hFFFF, 16'h0000, 1'b0);
    flags16("post", 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
